// File: rtl/igmii_tx_framer.sv
// IGMII transmit framer: wraps upstream frame bytes in preamble/SFD and enforces the inter-packet gap.
// Optional feature macro IGMII_TX_FCS_EN appends a CRC-32 FCS after the last byte of each frame.
module igmii_tx_framer #(
    parameter int IGMII_DW = 8,
    parameter int PRE_LEN  = 7,
    parameter int IPG_LEN  = 12
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clk_en,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [IGMII_DW-1:0] s_data,
    input  logic                s_last,
    input  logic                s_err,
    output logic                o_clk_en,
    output logic                o_dv,
    output logic [IGMII_DW-1:0] o_d,
    output logic                o_er
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_FCS  = 3'd3,
        ST_IPG  = 3'd4
    } state_t;

    localparam logic [3:0] PRE_CNT  = 4'(PRE_LEN);
    localparam logic [7:0] IPG_LAST = 8'(IPG_LEN - 1);
    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    state_t              state_r;
    state_t              state_s;
    logic [3:0]          pcnt_r;
    logic [3:0]          pcnt_s;
    logic [7:0]          icnt_r;
    logic [7:0]          icnt_s;
    logic                dv_r;
    logic                dv_s;
    logic [IGMII_DW-1:0] d_r;
    logic [IGMII_DW-1:0] d_s;
    logic                er_r;
    logic                er_s;
    logic                clk_en_r;

`ifdef IGMII_TX_FCS_EN
    logic [31:0]         crc_r;
    logic [31:0]         crc_s;
    logic [31:0]         fcs_s;
    logic [1:0]          fcnt_r;
    logic [1:0]          fcnt_s;

    // Reflected CRC-32 (poly 0x04C11DB7) advanced by one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 32'hEDB88320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    assign fcs_s = ~crc_r;
`endif

    assign s_ready  = (state_r == ST_DATA) & i_clk_en;
    assign o_clk_en = clk_en_r;
    assign o_dv     = dv_r;
    assign o_d      = d_r;
    assign o_er     = er_r;

    // Next state, counters and the byte to load into the output registers on a beat.
    always_comb begin
        state_s = state_r;
        pcnt_s  = pcnt_r;
        icnt_s  = icnt_r;
        dv_s    = 1'b0;
        d_s     = {IGMII_DW{1'b0}};
        er_s    = 1'b0;
`ifdef IGMII_TX_FCS_EN
        crc_s   = crc_r;
        fcnt_s  = fcnt_r;
`endif
        case (state_r)
            // The beat that first sees s_valid still drives idle; preamble starts on the next beat.
            ST_IDLE: begin
                pcnt_s = 4'd0;
                if (s_valid) begin
                    state_s = ST_PRE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRE: begin
                dv_s = 1'b1;
`ifdef IGMII_TX_FCS_EN
                crc_s = 32'hFFFF_FFFF;
`endif
                if (pcnt_r < PRE_CNT) begin
                    d_s    = PRE_BYTE;
                    pcnt_s = pcnt_r + 4'd1;
                end else begin
                    d_s     = SFD_BYTE;
                    pcnt_s  = 4'd0;
                    state_s = ST_DATA;
                end
            end
            ST_DATA: begin
                dv_s = 1'b1;
                if (s_valid) begin
                    d_s  = s_data;
                    er_s = s_err;
`ifdef IGMII_TX_FCS_EN
                    crc_s = crc32_byte(crc_r, s_data);
`endif
                    if (s_last) begin
                        icnt_s = 8'd0;
`ifdef IGMII_TX_FCS_EN
                        fcnt_s  = 2'd0;
                        state_s = ST_FCS;
`else
                        state_s = ST_IPG;
`endif
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    // Underrun: keep the frame going but poison it downstream.
                    d_s  = {IGMII_DW{1'b0}};
                    er_s = 1'b1;
`ifdef IGMII_TX_FCS_EN
                    crc_s = crc32_byte(crc_r, 8'h00);
`endif
                end
            end
`ifdef IGMII_TX_FCS_EN
            ST_FCS: begin
                dv_s   = 1'b1;
                d_s    = fcs_s[{fcnt_r, 3'b000} +: 8];
                fcnt_s = fcnt_r + 2'd1;
                if (fcnt_r == 2'd3) begin
                    state_s = ST_IPG;
                end else begin
                    state_s = ST_FCS;
                end
            end
`endif
            ST_IPG: begin
                if (icnt_r == IPG_LAST) begin
                    icnt_s  = 8'd0;
                    state_s = ST_IDLE;
                end else begin
                    icnt_s  = icnt_r + 8'd1;
                    state_s = ST_IPG;
                end
            end
            default: begin
                state_s = ST_IDLE;
                pcnt_s  = 4'd0;
                icnt_s  = 8'd0;
            end
        endcase
    end

    // FSM state register, advanced only on beats.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else if (i_clk_en) begin
            state_r <= state_s;
        end
    end

    // Counters and IGMII output registers, held between beats.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pcnt_r <= 4'd0;
            icnt_r <= 8'd0;
            dv_r   <= 1'b0;
            d_r    <= {IGMII_DW{1'b0}};
            er_r   <= 1'b0;
`ifdef IGMII_TX_FCS_EN
            crc_r  <= 32'hFFFF_FFFF;
            fcnt_r <= 2'd0;
`endif
        end else if (i_clk_en) begin
            pcnt_r <= pcnt_s;
            icnt_r <= icnt_s;
            dv_r   <= dv_s;
            d_r    <= d_s;
            er_r   <= er_s;
`ifdef IGMII_TX_FCS_EN
            crc_r  <= crc_s;
            fcnt_r <= fcnt_s;
`endif
        end
    end

    // Beat strobe delayed to line up with the registered data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_en_r <= 1'b0;
        end else begin
            clk_en_r <= i_clk_en;
        end
    end

endmodule
